// File: rtl/bus_mux_reg_if.sv
// Source/bus bundle for bus_mux_reg. The conflict_cnt signal exists only when
// BUS_CONFLICT_CNT_EN is defined.
interface bus_mux_reg_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 25
);
  localparam int SELW = $clog2(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_en;
  logic                  clr_sticky;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       sel_enc;
  logic                  conflict;
  logic                  conflict_sticky;
`ifdef BUS_CONFLICT_CNT_EN
  logic [7:0]            conflict_cnt;
`endif

  // master: whoever owns the sources; slave: the mux itself
  modport master (
`ifdef BUS_CONFLICT_CNT_EN
    input  conflict_cnt,
`endif
    output src_data, src_en, clr_sticky,
    input  bus_out, bus_valid, sel_enc, conflict, conflict_sticky
  );

  modport slave (
`ifdef BUS_CONFLICT_CNT_EN
    output conflict_cnt,
`endif
    input  src_data, src_en, clr_sticky,
    output bus_out, bus_valid, sel_enc, conflict, conflict_sticky
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered one-hot CPU bus mux: lowest-index priority, conflict pulse and a
// sticky fault FSM. BUS_CONFLICT_CNT_EN adds a saturating conflict counter.
module bus_mux_lane #(
    parameter int WIDTH = 32,
    parameter int SELW  = 5,
    parameter int IDX   = 0
) (
    input  logic             en,
    input  logic             any_below,
    input  logic [WIDTH-1:0] data,
    output logic             multi,
    output logic [WIDTH-1:0] data_m,
    output logic [SELW-1:0]  idx_m
);
    logic hit;

    // A lane wins only if no lower-index lane is enabled
    assign hit    = en & ~any_below;
    assign multi  = en & any_below;
    assign data_m = hit ? data : '0;
    assign idx_m  = hit ? SELW'(IDX) : '0;
endmodule

module bus_mux_reg #(
    parameter int WIDTH        = 32,
    parameter int NSRC         = 25,
    parameter int HOLD_ON_IDLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_mux_reg_if.slave  bus
);
    localparam int SELW = $clog2(NSRC);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FAULT} state_t;

    state_t state_q, state_d;

    logic [NSRC-1:0][WIDTH-1:0] src_w;
    logic [NSRC-1:0][WIDTH-1:0] data_m;
    logic [NSRC-1:0][SELW-1:0]  idx_m;
    logic [NSRC-1:0]            below;
    logic [NSRC-1:0]            multi;

    logic [WIDTH-1:0] data_sel;
    logic [SELW-1:0]  idx_sel;
    logic             any_en;
    logic             conflict_d;

    logic [WIDTH-1:0] bus_q;
    logic [SELW-1:0]  sel_q;
    logic             valid_q;
    logic             conflict_q;
    logic             sticky_q;

    assign src_w = bus.src_data;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_lane
            // Mask of all lanes strictly below this one
            localparam logic [NSRC-1:0] LOW = (NSRC'(1) << gi) - NSRC'(1);
            assign below[gi] = |(bus.src_en & LOW);

            bus_mux_lane #(
                .WIDTH (WIDTH),
                .SELW  (SELW),
                .IDX   (gi)
            ) u_lane (
                .en        (bus.src_en[gi]),
                .any_below (below[gi]),
                .data      (src_w[gi]),
                .multi     (multi[gi]),
                .data_m    (data_m[gi]),
                .idx_m     (idx_m[gi])
            );
        end
    endgenerate

    // At most one lane is a hit, so OR-reduction acts as the mux
    always_comb begin
        data_sel = '0;
        idx_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            data_sel = data_sel | data_m[i];
            idx_sel  = idx_sel  | idx_m[i];
        end
    end

    assign any_en     = |bus.src_en;
    assign conflict_d = |multi;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DRIVE: begin
                if (conflict_d)  state_d = S_FAULT;
                else if (any_en) state_d = S_DRIVE;
                else             state_d = S_IDLE;
            end
            S_FAULT: begin
                // A fresh conflict beats the clear request
                if (!conflict_d && bus.clr_sticky)
                    state_d = any_en ? S_DRIVE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q      <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            if (any_en) begin
                bus_q <= data_sel;
                sel_q <= idx_sel;
            end else if (HOLD_ON_IDLE == 0) begin
                bus_q <= '0;
            end
            valid_q    <= any_en;
            conflict_q <= conflict_d;
            sticky_q   <= (state_d == S_FAULT);
        end
    end

    assign bus.bus_out         = bus_q;
    assign bus.sel_enc         = sel_q;
    assign bus.bus_valid       = valid_q;
    assign bus.conflict        = conflict_q;
    assign bus.conflict_sticky = sticky_q;

`ifdef BUS_CONFLICT_CNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (conflict_d) begin
            // Clear coinciding with a conflict restarts the count at that conflict
            if (bus.clr_sticky)       cnt_q <= 8'd1;
            else if (cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
        end else if (bus.clr_sticky) begin
            cnt_q <= '0;
        end
    end

    assign bus.conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: per-cycle comparison against a behavioural
// model plus hand-computed literal checks.
module tb_bus_mux_reg;
  localparam int WIDTH = 32;
  localparam int NSRC  = 25;
  localparam int HOLD  = 1;

  logic clk;
  logic reset;
  logic [NSRC-1:0][WIDTH-1:0] src_w;

  bus_mux_reg_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bif ();

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_ON_IDLE(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  assign bif.src_data = src_w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: lowest set bit wins, fault flag is set by any
  // multi-enable cycle and cleared only by a clean clear request.
  logic [WIDTH-1:0] m_bus;
  logic [4:0]       m_sel;
  logic             m_valid, m_conf, m_sticky;
  int               m_cnt;

  always @(posedge clk) begin
    int n;
    int idx;
    n   = $countones(bif.src_en);
    idx = 0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (bif.src_en[i]) idx = i;
    if (reset) begin
      m_bus <= '0; m_sel <= '0; m_valid <= 0; m_conf <= 0; m_sticky <= 0; m_cnt <= 0;
    end else begin
      if (n > 0) begin
        m_bus <= src_w[idx];
        m_sel <= 5'(idx);
      end else if (HOLD == 0) begin
        m_bus <= '0;
      end
      m_valid  <= (n > 0);
      m_conf   <= (n > 1);
      m_sticky <= (n > 1) || (m_sticky && !bif.clr_sticky);
      if (n > 1)               m_cnt <= bif.clr_sticky ? 1 : (m_cnt >= 255 ? 255 : m_cnt + 1);
      else if (bif.clr_sticky) m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m.bus_out",   bif.bus_out,                 m_bus);
      chk("m.sel_enc",   32'(bif.sel_enc),            32'(m_sel));
      chk("m.bus_valid", 32'(bif.bus_valid),          32'(m_valid));
      chk("m.conflict",  32'(bif.conflict),           32'(m_conf));
      chk("m.sticky",    32'(bif.conflict_sticky),    32'(m_sticky));
`ifdef BUS_CONFLICT_CNT_EN
      chk("m.cnt",       32'(bif.conflict_cnt),       32'(m_cnt));
`endif
    end
  end

  // Apply inputs for one cycle; returns at the negedge after the capturing edge
  task automatic tick(input logic [NSRC-1:0] en, input logic clr);
    bif.src_en     = en;
    bif.clr_sticky = clr;
    @(negedge clk);
  endtask

  logic [NSRC-1:0] e;

  initial begin
    for (int i = 0; i < NSRC; i++) src_w[i] = 32'hC0DE_0000 + 32'(i);
    src_w[3]  = 32'hDEAD_BEEF;
    src_w[5]  = 32'h0000_00A5;
    src_w[2]  = 32'h1111_1111;
    src_w[0]  = 32'hA0A0_0000;
    src_w[24] = 32'hB024_B024;
    src_w[16] = 32'hC016_C016;
    reset = 1'b1;
    bif.src_en = '0;
    bif.clr_sticky = 1'b0;

    // Reset wins over an active enable
    e = NSRC'(1) << 3;
    tick(e, 1'b0);
    chk_on = 1'b1;
    tick(e, 1'b0);
    chk("rst.bus_out", bif.bus_out, 32'h0);
    chk("rst.valid",   32'(bif.bus_valid), 32'h0);
    chk("rst.sel",     32'(bif.sel_enc), 32'h0);
    chk("rst.sticky",  32'(bif.conflict_sticky), 32'h0);
    reset = 1'b0;

    // Single source then idle
    tick(NSRC'(1) << 5, 1'b0);
    chk("t2.bus_out", bif.bus_out, 32'h0000_00A5);
    chk("t2.sel",     32'(bif.sel_enc), 32'd5);
    chk("t2.valid",   32'(bif.bus_valid), 32'd1);
    tick('0, 1'b0);
    chk("t2.hold",    bif.bus_out, 32'h0000_00A5);
    chk("t2.idle_v",  32'(bif.bus_valid), 32'd0);
    chk("t2.sel_h",   32'(bif.sel_enc), 32'd5);

    // Conflict: lowest index driven, pulse and sticky flag
    tick((NSRC'(1) << 2) | (NSRC'(1) << 9), 1'b0);
    chk("t3.bus_out", bif.bus_out, 32'h1111_1111);
    chk("t3.sel",     32'(bif.sel_enc), 32'd2);
    chk("t3.conf",    32'(bif.conflict), 32'd1);
    chk("t3.sticky",  32'(bif.conflict_sticky), 32'd1);
    tick(NSRC'(1) << 4, 1'b0);
    chk("t3.pulse",   32'(bif.conflict), 32'd0);
    chk("t3.stk2",    32'(bif.conflict_sticky), 32'd1);
    tick('0, 1'b0);
    chk("t3.stk3",    32'(bif.conflict_sticky), 32'd1);

    // Clean clear leaves FAULT; clear with conflict stays
    tick(NSRC'(1) << 4, 1'b1);
    chk("t4.clr",     32'(bif.conflict_sticky), 32'd0);
    chk("t4.bus",     bif.bus_out, 32'hC0DE_0004);
    tick(NSRC'(3), 1'b0);
    chk("t4.refault", 32'(bif.conflict_sticky), 32'd1);
    tick(NSRC'(3), 1'b1);
    chk("t4.setwins", 32'(bif.conflict_sticky), 32'd1);
    chk("t4.conf",    32'(bif.conflict), 32'd1);
    chk("t4.bus0",    bif.bus_out, 32'hA0A0_0000);
    tick('0, 1'b1);
    chk("t4.clr2",    32'(bif.conflict_sticky), 32'd0);

    // Back-to-back sources
    tick(NSRC'(1), 1'b0);
    chk("t5.s0",   bif.bus_out, 32'hA0A0_0000);
    tick(NSRC'(1) << 24, 1'b0);
    chk("t5.s24",  bif.bus_out, 32'hB024_B024);
    chk("t5.sel24", 32'(bif.sel_enc), 32'd24);
    tick(NSRC'(1) << 16, 1'b0);
    chk("t5.s16",  bif.bus_out, 32'hC016_C016);
    chk("t5.sel16", 32'(bif.sel_enc), 32'd16);
    chk("t5.valid", 32'(bif.bus_valid), 32'd1);

    // Reset mid-transfer while in FAULT discards the pending word
    tick(NSRC'(3), 1'b0);
    reset = 1'b1;
    tick(NSRC'(1) << 7, 1'b0);
    chk("mrst.bus",    bif.bus_out, 32'h0);
    chk("mrst.valid",  32'(bif.bus_valid), 32'd0);
    chk("mrst.sticky", 32'(bif.conflict_sticky), 32'd0);
    reset = 1'b0;
    tick(NSRC'(1) << 7, 1'b0);
    chk("mrst.after", bif.bus_out, 32'hC0DE_0007);

`ifdef BUS_CONFLICT_CNT_EN
    for (int k = 0; k < 300; k++) tick(NSRC'(3), 1'b0);
    chk("t6.sat",  32'(bif.conflict_cnt), 32'd255);
    tick(NSRC'(1) << 4, 1'b1);
    chk("t6.clr",  32'(bif.conflict_cnt), 32'd0);
    tick(NSRC'(3), 1'b1);
    chk("t6.rst1", 32'(bif.conflict_cnt), 32'd1);
`endif

    // Random-ish tail exercised only against the model
    for (int k = 0; k < 40; k++) begin
      e = '0;
      case (k % 4)
        0: e = '0;
        1: e = NSRC'(1) << $urandom_range(NSRC - 1);
        2: e = (NSRC'(1) << $urandom_range(NSRC - 1)) | (NSRC'(1) << $urandom_range(NSRC - 1));
        default: e = NSRC'(1) << $urandom_range(NSRC - 1);
      endcase
      tick(e, 1'($urandom_range(1)));
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
